crc_gen_check: RTL

- Parametrised serial CRC engine for the USB link layer.
- Handles CRC5 for tokens and CRC16 for data packets through parameters.
- TX mode: accumulates CRC over the serial data stream, then shifts out the complemented CRC MSB-first with a ready/valid handshake.
- RX mode: accumulates over data plus the received CRC, then reports a residue check.

---
 rtl/crc_gen_check.sv | 116 +++++++++++
 1 files changed

// File: rtl/crc_gen_check.sv
// Serial CRC engine: accumulates a bit stream and either appends the complemented CRC (TX) or checks the residue (RX).
// CRC update is applied on the same edge that accepts a bit; appended bits are streamed MSB-first with a valid/ready handshake.
module crc_gen_check #(
  parameter int unsigned      WIDTH   = 5,
  parameter logic [WIDTH-1:0] POLY    = 5'b00101,
  parameter logic [WIDTH-1:0] INIT    = '1,
  parameter logic [WIDTH-1:0] RESIDUE = 5'b01100
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             mode,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             data_done,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic [WIDTH-1:0] crc_q,
  output logic             busy,
  output logic             done,
  output logic             crc_ok
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    APPEND = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] crc_d;
  logic [WIDTH-1:0] crc_upd;
  logic [WIDTH-1:0] crc_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_d;
  logic             ok_d;
  logic             busy_d;
  logic             fb;

  assign fb      = crc_q[WIDTH-1] ^ bit_in;
  assign crc_upd = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

  // Counter selects which register bit is presented; shifting keeps the index in-range.
  assign crc_sh    = crc_q << cnt_q;
  assign out_valid = (state_q == APPEND);
  assign out_bit   = out_valid & ~crc_sh[WIDTH-1];

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ok_d    = crc_ok;
    done_d  = 1'b0;

    if (start) begin
      state_d = DATA;
      crc_d   = INIT;
      cnt_d   = '0;
      mode_d  = mode;
      ok_d    = 1'b0;
    end else begin
      case (state_q)
        DATA: begin
          if (bit_valid) crc_d = crc_upd;
          if (data_done) state_d = mode_q ? CHECK : APPEND;
        end
        APPEND: begin
          if (out_ready) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        CHECK: begin
          ok_d    = (crc_q == RESIDUE);
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done    <= 1'b0;
      crc_ok  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done    <= done_d;
      crc_ok  <= ok_d;
      busy    <= busy_d;
    end
  end

endmodule
